// File: rtl/mmio_app_router.sv
// MMIO router: splits the host MMIO window into equal per-app sub-windows.
// Writes are forwarded with one cycle of latency. Reads are queued and
// serialised one at a time to the target app. Every accepted read gets a
// response, either from the app or from a timeout.
module mmio_app_router #(
    parameter int                    NUM_APPS       = 2,
    parameter int                    ADDR_WIDTH     = 16,
    parameter int                    DATA_WIDTH     = 64,
    parameter int                    TID_WIDTH      = 9,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = ADDR_WIDTH'(16'h0050),
    parameter int unsigned           APP_WINDOW     = 32'h0100,
    parameter int                    LOCAL_WIDTH    = $clog2(APP_WINDOW),
    parameter int                    RD_FIFO_DEPTH  = 4,
    parameter int                    TIMEOUT_CYCLES = 512,
    parameter logic [DATA_WIDTH-1:0] TIMEOUT_DATA   = DATA_WIDTH'(64'hDEAD_DEAD_DEAD_DEAD)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           mmio_wr_en,
    input  logic [ADDR_WIDTH-1:0]          mmio_wr_addr,
    input  logic [DATA_WIDTH-1:0]          mmio_wr_data,
    input  logic                           mmio_rd_en,
    input  logic [ADDR_WIDTH-1:0]          mmio_rd_addr,
    input  logic [TID_WIDTH-1:0]           mmio_rd_tid,
    output logic                           mmio_rd_rsp_valid,
    output logic [DATA_WIDTH-1:0]          mmio_rd_rsp_data,
    output logic [TID_WIDTH-1:0]           mmio_rd_rsp_tid,
    output logic [NUM_APPS-1:0]            app_wr_en,
    output logic [LOCAL_WIDTH-1:0]         app_wr_addr,
    output logic [DATA_WIDTH-1:0]          app_wr_data,
    output logic [NUM_APPS-1:0]            app_rd_en,
    output logic [LOCAL_WIDTH-1:0]         app_rd_addr,
    input  logic [NUM_APPS-1:0]            app_rd_valid,
    input  logic [NUM_APPS*DATA_WIDTH-1:0] app_rd_data,
    output logic [15:0]                    rd_timeout_count,
    output logic                           rd_overflow
);

    localparam int IDX_W = (NUM_APPS > 1) ? $clog2(NUM_APPS) : 1;
    localparam int HI_W  = ADDR_WIDTH - LOCAL_WIDTH;
    localparam int PW    = (RD_FIFO_DEPTH > 1) ? $clog2(RD_FIFO_DEPTH) : 1;
    localparam int TW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [HI_W-1:0] NUM_APPS_HI = HI_W'(NUM_APPS);

    typedef struct packed {
        logic                   in_win;
        logic [IDX_W-1:0]       idx;
        logic [LOCAL_WIDTH-1:0] loc;
        logic [TID_WIDTH-1:0]   tid;
    } rd_entry_t;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    logic [ADDR_WIDTH-1:0] wr_off, rd_off;
    logic                  wr_in, rd_in;
    logic [IDX_W-1:0]      wr_idx;

    rd_entry_t fifo_mem [RD_FIFO_DEPTH];
    rd_entry_t head, rd_new;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;
    logic          fifo_full, push, pop;

    state_t                state;
    logic [TW-1:0]         timer;
    logic                  sel_valid;
    logic [DATA_WIDTH-1:0] sel_data;

    // Address decode for both host ports
    always_comb begin
        wr_off = mmio_wr_addr - BASE_ADDR;
        rd_off = mmio_rd_addr - BASE_ADDR;
        wr_in  = (mmio_wr_addr >= BASE_ADDR) && (wr_off[ADDR_WIDTH-1:LOCAL_WIDTH] < NUM_APPS_HI);
        rd_in  = (mmio_rd_addr >= BASE_ADDR) && (rd_off[ADDR_WIDTH-1:LOCAL_WIDTH] < NUM_APPS_HI);
        wr_idx = wr_off[LOCAL_WIDTH +: IDX_W];
        rd_new = '{in_win: rd_in,
                   idx:    rd_off[LOCAL_WIDTH +: IDX_W],
                   loc:    rd_off[LOCAL_WIDTH-1:0],
                   tid:    mmio_rd_tid};
    end

    // Forward in-window writes to the selected app one cycle later
    always_ff @(posedge clk) begin
        if (rst) begin
            app_wr_en   <= '0;
            app_wr_addr <= '0;
            app_wr_data <= '0;
        end else begin
            app_wr_en <= '0;
            if (mmio_wr_en && wr_in) begin
                app_wr_en   <= NUM_APPS'(1) << wr_idx;
                app_wr_addr <= wr_off[LOCAL_WIDTH-1:0];
                app_wr_data <= mmio_wr_data;
            end
        end
    end

    // Full check uses pre-pop occupancy, so a read arriving while full is dropped
    assign fifo_full = (count == (PW+1)'(RD_FIFO_DEPTH));
    assign push      = mmio_rd_en && !fifo_full;
    assign pop       = (state == S_RESP);
    assign head      = fifo_mem[rd_ptr];

    // Pending-read storage
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= rd_new;
    end

    // Queue pointers, occupancy and sticky overflow flag
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            rd_overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + (PW+1)'(push) - (PW+1)'(pop);
            if (mmio_rd_en && fifo_full) rd_overflow <= 1'b1;
        end
    end

    // Select the strobe and data of the app owning the head read
    always_comb begin
        sel_valid = 1'b0;
        sel_data  = '0;
        for (int unsigned i = 0; i < NUM_APPS; i++) begin
            if (head.idx == IDX_W'(i)) begin
                sel_valid = app_rd_valid[i];
                sel_data  = app_rd_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Read sequencer: issue head read, wait for data or timeout, respond, pop
    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= S_IDLE;
            timer             <= '0;
            app_rd_en         <= '0;
            app_rd_addr       <= '0;
            mmio_rd_rsp_valid <= 1'b0;
            mmio_rd_rsp_data  <= '0;
            mmio_rd_rsp_tid   <= '0;
            rd_timeout_count  <= '0;
        end else begin
            app_rd_en         <= '0;
            mmio_rd_rsp_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (count != '0) begin
                        if (head.in_win) begin
                            app_rd_en   <= NUM_APPS'(1) << head.idx;
                            app_rd_addr <= head.loc;
                            state       <= S_ISSUE;
                        end else begin
                            mmio_rd_rsp_valid <= 1'b1;
                            mmio_rd_rsp_data  <= '0;
                            mmio_rd_rsp_tid   <= head.tid;
                            state             <= S_RESP;
                        end
                    end
                end
                S_ISSUE: begin
                    timer <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (sel_valid) begin
                        mmio_rd_rsp_valid <= 1'b1;
                        mmio_rd_rsp_data  <= sel_data;
                        mmio_rd_rsp_tid   <= head.tid;
                        state             <= S_RESP;
                    end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
                        mmio_rd_rsp_valid <= 1'b1;
                        mmio_rd_rsp_data  <= TIMEOUT_DATA;
                        mmio_rd_rsp_tid   <= head.tid;
                        if (rd_timeout_count != 16'hFFFF)
                            rd_timeout_count <= rd_timeout_count + 16'd1;
                        state <= S_RESP;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_app_router.sv
// Self-checking bench for mmio_app_router (NUM_APPS=2, TIMEOUT_CYCLES=16).
module tb_mmio_app_router;

    localparam int NA = 2;
    localparam int AW = 16;
    localparam int DW = 64;
    localparam int TW = 9;
    localparam int LW = 8;
    localparam int TO = 16;
    localparam logic [DW-1:0] DEAD = 64'hDEAD_DEAD_DEAD_DEAD;

    logic            clk, rst;
    logic            mmio_wr_en, mmio_rd_en;
    logic [AW-1:0]   mmio_wr_addr, mmio_rd_addr;
    logic [DW-1:0]   mmio_wr_data;
    logic [TW-1:0]   mmio_rd_tid;
    logic            mmio_rd_rsp_valid;
    logic [DW-1:0]   mmio_rd_rsp_data;
    logic [TW-1:0]   mmio_rd_rsp_tid;
    logic [NA-1:0]   app_wr_en, app_rd_en, app_rd_valid;
    logic [LW-1:0]   app_wr_addr, app_rd_addr;
    logic [DW-1:0]   app_wr_data;
    logic [NA*DW-1:0] app_rd_data;
    logic [15:0]     rd_timeout_count;
    logic            rd_overflow;

    logic [NA-1:0]    resp_v, stray_v;
    logic [NA*DW-1:0] resp_d, stray_d;
    assign app_rd_valid = resp_v | stray_v;
    assign app_rd_data  = resp_d | stray_d;

    mmio_app_router #(.NUM_APPS(NA), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .mmio_wr_en(mmio_wr_en), .mmio_wr_addr(mmio_wr_addr), .mmio_wr_data(mmio_wr_data),
        .mmio_rd_en(mmio_rd_en), .mmio_rd_addr(mmio_rd_addr), .mmio_rd_tid(mmio_rd_tid),
        .mmio_rd_rsp_valid(mmio_rd_rsp_valid), .mmio_rd_rsp_data(mmio_rd_rsp_data),
        .mmio_rd_rsp_tid(mmio_rd_rsp_tid),
        .app_wr_en(app_wr_en), .app_wr_addr(app_wr_addr), .app_wr_data(app_wr_data),
        .app_rd_en(app_rd_en), .app_rd_addr(app_rd_addr),
        .app_rd_valid(app_rd_valid), .app_rd_data(app_rd_data),
        .rd_timeout_count(rd_timeout_count), .rd_overflow(rd_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [TW-1:0] tid;
        logic [DW-1:0] data;
    } rsp_t;

    int n_checks = 0;
    int n_fail   = 0;
    logic [DW-1:0] app_mem [NA][256];
    logic [NA-1:0] app_dead = '0;
    int            fixed_delay = 0;
    rsp_t          obs_q[$];
    rsp_t          exp_q[$];

    // Behavioural app: answers a read strobe after a delay unless marked dead
    initial begin
        resp_v = '0;
        resp_d = '0;
        forever begin
            @(posedge clk); #1;
            if (app_rd_en != '0 && !rst) begin
                int a;
                int d;
                logic [LW-1:0] la;
                a  = app_rd_en[1] ? 1 : 0;
                la = app_rd_addr;
                d  = (fixed_delay > 0) ? fixed_delay : int'($urandom_range(1, 4));
                if (!app_dead[a]) begin
                    repeat (d) begin @(posedge clk); #1; end
                    if (!rst) begin
                        resp_v[a] = 1'b1;
                        resp_d[a*DW +: DW] = app_mem[a][la];
                        @(posedge clk); #1;
                        resp_v = '0;
                        resp_d = '0;
                    end
                end
            end
        end
    end

    // Response monitor
    initial begin
        forever begin
            @(posedge clk); #1;
            if (mmio_rd_rsp_valid === 1'b1)
                obs_q.push_back('{tid: mmio_rd_rsp_tid, data: mmio_rd_rsp_data});
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick(input int n = 1);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        mmio_wr_en = 1'b0; mmio_rd_en = 1'b0;
        mmio_wr_addr = '0; mmio_rd_addr = '0; mmio_wr_data = '0; mmio_rd_tid = '0;
        stray_v = '0; stray_d = '0;
        tick(2);
        rst = 1'b0;
        tick(1);
        obs_q.delete();
    endtask

    // Spec decode: returns -1 when out of window
    function automatic int app_of(input int addr);
        if (addr < 'h50 || (addr - 'h50) / 256 >= NA) return -1;
        return (addr - 'h50) / 256;
    endfunction

    task automatic test_reset();
        n_checks++; if (mmio_rd_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b expected 0", mmio_rd_rsp_valid); end
        n_checks++; if (mmio_rd_rsp_data !== '0 || mmio_rd_rsp_tid !== '0) begin n_fail++; $display("FAIL reset_rsp_fields: got %h/%h expected 0/0", mmio_rd_rsp_data, mmio_rd_rsp_tid); end
        n_checks++; if (app_wr_en !== '0 || app_wr_addr !== '0 || app_wr_data !== '0) begin n_fail++; $display("FAIL reset_wr: got %b/%h/%h expected 0", app_wr_en, app_wr_addr, app_wr_data); end
        n_checks++; if (app_rd_en !== '0 || app_rd_addr !== '0) begin n_fail++; $display("FAIL reset_rd: got %b/%h expected 0", app_rd_en, app_rd_addr); end
        n_checks++; if (rd_timeout_count !== 16'd0 || rd_overflow !== 1'b0) begin n_fail++; $display("FAIL reset_status: got %0d/%b expected 0/0", rd_timeout_count, rd_overflow); end
    endtask

    task automatic test_write();
        logic [NA-1:0] exp_en;
        logic [LW-1:0] exp_loc;
        logic [DW-1:0] exp_dat;
        int a;
        mmio_wr_en = 1'b1; mmio_wr_addr = 16'h0150; mmio_wr_data = 64'h55;
        tick(1);
        mmio_wr_en = 1'b0;
        n_checks++; if (app_wr_en !== 2'b10) begin n_fail++; $display("FAIL wr_en_app1: got %b expected 10", app_wr_en); end
        n_checks++; if (app_wr_addr !== 8'h00) begin n_fail++; $display("FAIL wr_addr_app1: got %h expected 00", app_wr_addr); end
        n_checks++; if (app_wr_data !== 64'h55) begin n_fail++; $display("FAIL wr_data_app1: got %h expected 55", app_wr_data); end
        tick(1);
        n_checks++; if (app_wr_en !== 2'b00) begin n_fail++; $display("FAIL wr_en_one_cycle: got %b expected 00", app_wr_en); end
        mmio_wr_en = 1'b1; mmio_wr_addr = 16'h0040;
        tick(1);
        mmio_wr_en = 1'b0;
        n_checks++; if (app_wr_en !== 2'b00) begin n_fail++; $display("FAIL wr_below_base: got %b expected 00", app_wr_en); end
        for (int i = 0; i < 30; i++) begin
            mmio_wr_en   = ($urandom_range(0, 3) != 0);
            mmio_wr_addr = 16'($urandom_range(16'h0030, 16'h0280));
            mmio_wr_data = {$urandom, $urandom};
            a = app_of(int'(mmio_wr_addr));
            exp_en  = (mmio_wr_en && a >= 0) ? NA'(1 << a) : '0;
            exp_loc = 8'((int'(mmio_wr_addr) - 'h50) % 256);
            exp_dat = mmio_wr_data;
            tick(1);
            n_checks++; if (app_wr_en !== exp_en) begin n_fail++; $display("FAIL wr_rand_en[%0d]: got %b expected %b", i, app_wr_en, exp_en); end
            if (exp_en != '0) begin
                n_checks++; if (app_wr_addr !== exp_loc || app_wr_data !== exp_dat) begin n_fail++; $display("FAIL wr_rand_payload[%0d]: got %h/%h expected %h/%h", i, app_wr_addr, app_wr_data, exp_loc, exp_dat); end
            end
        end
        mmio_wr_en = 1'b0;
        tick(1);
    endtask

    task automatic test_read_in();
        int rsp_k = 0;
        logic [DW-1:0] gd = '0;
        logic [TW-1:0] gt = '0;
        fixed_delay = 1; app_dead = '0;
        app_mem[0][3] = 64'h1234;
        mmio_rd_en = 1'b1; mmio_rd_addr = 16'h0053; mmio_rd_tid = 9'h1A2;
        for (int k = 1; k <= 8; k++) begin
            tick(1);
            if (k == 1) mmio_rd_en = 1'b0;
            if (k == 2) begin
                n_checks++; if (app_rd_en !== 2'b01 || app_rd_addr !== 8'h03) begin n_fail++; $display("FAIL rd_issue: got %b/%h expected 01/03", app_rd_en, app_rd_addr); end
            end
            if (mmio_rd_rsp_valid === 1'b1 && rsp_k == 0) begin rsp_k = k; gd = mmio_rd_rsp_data; gt = mmio_rd_rsp_tid; end
        end
        n_checks++; if (rsp_k != 4) begin n_fail++; $display("FAIL rd_latency: got %0d expected 4", rsp_k); end
        n_checks++; if (gd !== 64'h1234 || gt !== 9'h1A2) begin n_fail++; $display("FAIL rd_in_rsp: got %h/%h expected 1234/1a2", gd, gt); end
        fixed_delay = 0;
    endtask

    task automatic test_read_oow();
        int rsp_k = 0;
        bit saw_en = 0;
        logic [DW-1:0] gd = '1;
        logic [TW-1:0] gt = '0;
        mmio_rd_en = 1'b1; mmio_rd_addr = 16'h0250; mmio_rd_tid = 9'h0C3;
        for (int k = 1; k <= 6; k++) begin
            tick(1);
            if (k == 1) mmio_rd_en = 1'b0;
            if (app_rd_en != '0) saw_en = 1;
            if (mmio_rd_rsp_valid === 1'b1 && rsp_k == 0) begin rsp_k = k; gd = mmio_rd_rsp_data; gt = mmio_rd_rsp_tid; end
        end
        n_checks++; if (rsp_k != 2) begin n_fail++; $display("FAIL oow_latency: got %0d expected 2", rsp_k); end
        n_checks++; if (gd !== '0 || gt !== 9'h0C3) begin n_fail++; $display("FAIL oow_rsp: got %h/%h expected 0/0c3", gd, gt); end
        n_checks++; if (saw_en) begin n_fail++; $display("FAIL oow_no_issue: got app_rd_en pulse expected none"); end
    endtask

    task automatic test_timeout();
        int rsp_k = 0;
        logic [DW-1:0] gd = '0;
        logic [TW-1:0] gt = '0;
        app_dead = 2'b01;
        mmio_rd_en = 1'b1; mmio_rd_addr = 16'h0050; mmio_rd_tid = 9'h0AB;
        for (int k = 1; k <= 60 && rsp_k == 0; k++) begin
            tick(1);
            if (k == 1) mmio_rd_en = 1'b0;
            if (k == 5) begin stray_v = 2'b10; stray_d[DW +: DW] = 64'h1111; end
            if (k == 7) begin stray_v = '0; stray_d = '0; end
            if (mmio_rd_rsp_valid === 1'b1) begin rsp_k = k; gd = mmio_rd_rsp_data; gt = mmio_rd_rsp_tid; end
        end
        n_checks++; if (rsp_k < TO) begin n_fail++; $display("FAIL to_latency: got %0d expected >= %0d", rsp_k, TO); end
        n_checks++; if (gd !== DEAD || gt !== 9'h0AB) begin n_fail++; $display("FAIL to_rsp: got %h/%h expected %h/0ab", gd, gt, DEAD); end
        n_checks++; if (rd_timeout_count !== 16'd1) begin n_fail++; $display("FAIL to_count: got %0d expected 1", rd_timeout_count); end
        tick(2);
    endtask

    task automatic test_back_to_back();
        app_dead = 2'b01;
        obs_q.delete();
        for (int i = 1; i <= 5; i++) begin
            mmio_rd_en = 1'b1; mmio_rd_addr = 16'(16'h0050 + i); mmio_rd_tid = 9'(i);
            tick(1);
        end
        mmio_rd_en = 1'b0;
        n_checks++; if (rd_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b expected 1", rd_overflow); end
        for (int c = 0; c < 300 && obs_q.size() < 4; c++) tick(1);
        tick(40);
        n_checks++; if (obs_q.size() != 4) begin n_fail++; $display("FAIL ovf_count: got %0d expected 4", obs_q.size()); end
        for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
            n_checks++; if (obs_q[i].tid !== 9'(i + 1) || obs_q[i].data !== DEAD) begin n_fail++; $display("FAIL ovf_order[%0d]: got %h/%h expected %h/%h", i, obs_q[i].tid, obs_q[i].data, 9'(i + 1), DEAD); end
        end
        n_checks++; if (rd_timeout_count !== 16'd5 || rd_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_status: got %0d/%b expected 5/1", rd_timeout_count, rd_overflow); end
    endtask

    task automatic test_reset_mid();
        app_dead = 2'b01;
        mmio_rd_en = 1'b1; mmio_rd_addr = 16'h0051; mmio_rd_tid = 9'h055;
        tick(1);
        mmio_rd_en = 1'b0;
        tick(4);
        obs_q.delete();
        rst = 1'b1;
        tick(1);
        n_checks++; if ({mmio_rd_rsp_valid, app_rd_en, app_wr_en, rd_overflow} !== '0 || rd_timeout_count !== '0) begin n_fail++; $display("FAIL midrst_outputs: got %b%b%b%b/%0d expected zeros", mmio_rd_rsp_valid, app_rd_en, app_wr_en, rd_overflow, rd_timeout_count); end
        n_checks++; if (mmio_rd_rsp_data !== '0 || mmio_rd_rsp_tid !== '0 || app_rd_addr !== '0) begin n_fail++; $display("FAIL midrst_fields: got %h/%h/%h expected zeros", mmio_rd_rsp_data, mmio_rd_rsp_tid, app_rd_addr); end
        tick(1);
        rst = 1'b0;
        stray_v = 2'b01; stray_d[0 +: DW] = 64'hBAD;
        tick(2);
        stray_v = '0; stray_d = '0;
        tick(30);
        n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL midrst_no_rsp: got %0d responses expected 0", obs_q.size()); end
        app_dead = '0;
        mmio_rd_en = 1'b1; mmio_rd_addr = 16'h0152; mmio_rd_tid = 9'h077;
        tick(1);
        mmio_rd_en = 1'b0;
        for (int c = 0; c < 60 && obs_q.size() < 1; c++) tick(1);
        n_checks++; if (obs_q.size() != 1) begin n_fail++; $display("FAIL midrst_recover_cnt: got %0d expected 1", obs_q.size()); end
        else if (obs_q[0].tid !== 9'h077 || obs_q[0].data !== app_mem[1][2]) begin n_fail++; $display("FAIL midrst_recover: got %h/%h expected 077/%h", obs_q[0].tid, obs_q[0].data, app_mem[1][2]); end
    endtask

    task automatic test_random();
        int exp_to = 0;
        int nb, a;
        for (int b = 0; b < 12; b++) begin
            app_dead = ($urandom_range(0, 3) == 0) ? NA'($urandom) : '0;
            obs_q.delete();
            exp_q.delete();
            nb = $urandom_range(1, 4);
            for (int r = 0; r < nb; r++) begin
                rsp_t e;
                mmio_rd_en   = 1'b1;
                mmio_rd_addr = 16'($urandom_range(16'h0040, 16'h0270));
                mmio_rd_tid  = 9'($urandom);
                a = app_of(int'(mmio_rd_addr));
                e.tid = mmio_rd_tid;
                if (a < 0) e.data = '0;
                else if (app_dead[a]) begin e.data = DEAD; exp_to++; end
                else e.data = app_mem[a][(int'(mmio_rd_addr) - 'h50) % 256];
                exp_q.push_back(e);
                tick(1);
            end
            mmio_rd_en = 1'b0;
            for (int c = 0; c < 400 && obs_q.size() < nb; c++) tick(1);
            n_checks++; if (obs_q.size() != nb) begin n_fail++; $display("FAIL rand_cnt[%0d]: got %0d expected %0d", b, obs_q.size(), nb); end
            for (int r = 0; r < nb && r < obs_q.size(); r++) begin
                n_checks++; if (obs_q[r].tid !== exp_q[r].tid || obs_q[r].data !== exp_q[r].data) begin n_fail++; $display("FAIL rand_rsp[%0d.%0d]: got %h/%h expected %h/%h", b, r, obs_q[r].tid, obs_q[r].data, exp_q[r].tid, exp_q[r].data); end
            end
            n_checks++; if (rd_timeout_count !== 16'(exp_to)) begin n_fail++; $display("FAIL rand_tocount[%0d]: got %0d expected %0d", b, rd_timeout_count, exp_to); end
            tick(3);
        end
    endtask

    initial begin
        for (int i = 0; i < NA; i++)
            for (int j = 0; j < 256; j++)
                app_mem[i][j] = {$urandom, $urandom};
        do_reset();
        test_reset();
        test_write();
        test_read_in();
        test_read_oow();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        do_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
